// File: rtl/sse_stream_ctrl_if.sv
// Handshake and status bundle between the SSE sequencing controller and the
// surrounding FIFOs / SSE core.
//   master : controller side (drives sel_ready, sse_*, img_fifo_ready,
//            ack_*, busy, frame_done, in_count, out_count)
//   slave  : environment side (drives chan_open, sel_valid/bits,
//            sse_select_ready, img_fifo_valid, sse_in_ready, sse_out_fire,
//            ack_ready)
interface sse_stream_ctrl_if #(
  parameter int unsigned CNT_W = 20
);
  logic             chan_open;
  logic             sel_valid;
  logic             sel_ready;
  logic [7:0]       sel_bits;
  logic             sse_reset;
  logic             sse_select_valid;
  logic             sse_select_ready;
  logic [7:0]       sse_select_bits;
  logic             img_fifo_valid;
  logic             img_fifo_ready;
  logic             sse_in_valid;
  logic             sse_in_ready;
  logic             sse_out_fire;
  logic             ack_valid;
  logic             ack_ready;
  logic [7:0]       ack_bits;
  logic             busy;
  logic             frame_done;
  logic [CNT_W-1:0] in_count;
  logic [CNT_W-1:0] out_count;

  modport master (
    input  chan_open, sel_valid, sel_bits, sse_select_ready, img_fifo_valid,
           sse_in_ready, sse_out_fire, ack_ready,
    output sel_ready, sse_reset, sse_select_valid, sse_select_bits,
           img_fifo_ready, sse_in_valid, ack_valid, ack_bits, busy,
           frame_done, in_count, out_count
  );

  modport slave (
    output chan_open, sel_valid, sel_bits, sse_select_ready, img_fifo_valid,
           sse_in_ready, sse_out_fire, ack_ready,
    input  sel_ready, sse_reset, sse_select_valid, sse_select_bits,
           img_fifo_ready, sse_in_valid, ack_valid, ack_bits, busy,
           frame_done, in_count, out_count
  );
endinterface

// File: rtl/sse_stream_ctrl.sv
// Sequencing controller for the ScaleSpaceExtrema stream datapath.
// Takes a select byte, holds SSE in reset for RST_CYCLES, hands the select
// to SSE, writes a sequence-numbered ack, then gates exactly one frame of
// image words into SSE and counts the words it emits.
// Ports:
//   bus_clk  - clock
//   reset_n  - asynchronous active-low reset
//   bus      - sse_stream_ctrl_if.master (select/ack/image handshakes, status)
module sse_stream_ctrl #(
  parameter int unsigned FRAME_WORDS = 307200,
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned CNT_W       = 20
) (
  input  logic              bus_clk,
  input  logic              reset_n,
  sse_stream_ctrl_if.master bus
);

  localparam int unsigned RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RST  = 3'd1;
  localparam logic [2:0] S_SEL  = 3'd2;
  localparam logic [2:0] S_ACK  = 3'd3;
  localparam logic [2:0] S_RUN  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [CNT_W-1:0] FRAME_LEN  = CNT_W'(FRAME_WORDS);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_WORDS - 1);
  localparam logic [RST_W-1:0] RST_LOAD   = RST_W'(RST_CYCLES - 1);

  logic [2:0]       state, state_d;
  logic [7:0]       sel_q, sel_d;
  logic [7:0]       seq, seq_d;
  logic [RST_W-1:0] rst_cnt, rst_cnt_d;
  logic [CNT_W-1:0] in_cnt, in_cnt_d;
  logic [CNT_W-1:0] out_cnt, out_cnt_d;
  logic             gate;
  logic             in_xfer;
  logic             take_sel;

  // Frame gate: stop admitting words once a full frame has entered SSE.
  assign gate    = (in_cnt < FRAME_LEN);
  assign in_xfer = (state == S_RUN) && bus.sse_in_ready && bus.img_fifo_valid && gate;
  // A select byte is consumed only from IDLE or RUN (RUN means abort).
  assign take_sel = bus.sel_valid && bus.chan_open &&
                    ((state == S_IDLE) || (state == S_RUN));

  assign bus.busy      = (state != S_IDLE);
  assign bus.in_count  = in_cnt;
  assign bus.out_count = out_cnt;

  // State and datapath registers.
  always_ff @(posedge bus_clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      sel_q   <= 8'h00;
      seq     <= 8'h00;
      rst_cnt <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      state   <= state_d;
      sel_q   <= sel_d;
      seq     <= seq_d;
      rst_cnt <= rst_cnt_d;
      in_cnt  <= in_cnt_d;
      out_cnt <= out_cnt_d;
    end
  end

  // Next-state and outputs.
  always_comb begin
    state_d   = state;
    sel_d     = sel_q;
    seq_d     = seq;
    rst_cnt_d = rst_cnt;
    in_cnt_d  = in_cnt;
    out_cnt_d = out_cnt;

    bus.sse_reset        = 1'b0;
    bus.sel_ready        = 1'b0;
    bus.sse_select_valid = 1'b0;
    bus.sse_select_bits  = 8'h00;
    bus.sse_in_valid     = 1'b0;
    bus.img_fifo_ready   = 1'b0;
    bus.ack_valid        = 1'b0;
    bus.ack_bits         = 8'h00;
    bus.frame_done       = 1'b0;

    case (state)
      S_IDLE: begin
        bus.sse_reset = ~bus.chan_open;
      end
      S_RST: begin
        bus.sse_reset = 1'b1;
        if (rst_cnt == '0) state_d = S_SEL;
        else               rst_cnt_d = rst_cnt - RST_W'(1);
      end
      S_SEL: begin
        bus.sse_select_valid = 1'b1;
        bus.sse_select_bits  = sel_q;
        if (bus.sse_select_ready) begin
          seq_d   = seq + 8'd1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        // The write strobe follows ack_ready so the ack is never lost.
        bus.ack_valid = bus.ack_ready;
        bus.ack_bits  = seq;
        if (bus.ack_ready) state_d = S_RUN;
      end
      S_RUN: begin
        bus.sse_in_valid   = bus.img_fifo_valid && gate;
        bus.img_fifo_ready = in_xfer;
        if (in_xfer)          in_cnt_d  = in_cnt + CNT_W'(1);
        if (bus.sse_out_fire) out_cnt_d = out_cnt + CNT_W'(1);
        // A new select aborts the frame, so it outranks completion.
        if (!take_sel && bus.chan_open && bus.sse_out_fire && (out_cnt == FRAME_LAST)) begin
          bus.frame_done = 1'b1;
          state_d        = S_DONE;
        end
      end
      S_DONE: begin
        in_cnt_d  = '0;
        out_cnt_d = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (take_sel) begin
      bus.sel_ready = 1'b1;
      sel_d         = bus.sel_bits;
      rst_cnt_d     = RST_LOAD;
      in_cnt_d      = '0;
      out_cnt_d     = '0;
      state_d       = S_RST;
    end

    // Channel close mirrors the FIFO srst: everything returns to idle.
    if (!bus.chan_open) begin
      state_d   = S_IDLE;
      in_cnt_d  = '0;
      out_cnt_d = '0;
      seq_d     = 8'h00;
    end
  end

endmodule
